// File: rtl/fig_writer_if.sv
// fig_writer_if: control, token stream and RAM write port of the figure slot loader
interface fig_writer_if;
  logic        start;
  logic [1:0]  fig_select;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [5:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overrun;
  modport master (
    output start, fig_select, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, overrun
  );
  modport slave (
    input  start, fig_select, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, overrun
  );
endinterface

// File: rtl/fig_writer.sv
// fig_writer: expands run-length palette tokens into raster-order writes of one figure RAM slot
module fig_writer #(
  parameter int FIG_X_SIZE = 128,
  parameter int FIG_Y_SIZE = 256
) (
  input  logic         pixel_clk_i,
  input  logic         reset_n_i,
  fig_writer_if.slave  bus
);
  localparam int PIX = FIG_X_SIZE * FIG_Y_SIZE;
  localparam int PW = $clog2(PIX);
  localparam logic [PW-1:0] LAST = PW'(PIX - 1);
  localparam logic [16:0] PIX17 = 17'(PIX);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t        state_q;
  logic [16:0]   base_q;
  logic [16:0]   wr_addr_q;
  logic [PW-1:0] p_q;
  logic [1:0]    rem_q;
  logic [5:0]    idx_q;
  logic [5:0]    wr_data_q;
  logic          wr_en_q;
  logic          busy_q;
  logic          done_q;
  logic          overrun_q;
  logic          take_d;
  logic          wr_d;
  logic          last_d;
  logic [1:0]    left_d;
  logic [5:0]    pix_d;
  // a write happens on an accepted token or an expansion cycle, unless abort kills it
  always_comb begin
    take_d = state_q == LOAD && bus.in_valid && !bus.abort;
    wr_d   = take_d || (state_q == EXPAND && !bus.abort);
    left_d = take_d ? bus.in_data[7:6] : rem_q - 2'd1;
    pix_d  = take_d ? bus.in_data[5:0] : idx_q;
    last_d = p_q == LAST;
  end
  // loader FSM with registered write port and status outputs
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      p_q       <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_en_q <= wr_d;
      done_q  <= wr_d && last_d;
      if (wr_d) begin
        wr_addr_q <= base_q + 17'(p_q);
        wr_data_q <= pix_d;
        idx_q     <= pix_d;
        rem_q     <= left_d;
        p_q       <= p_q + PW'(1);
      end
      if (state_q == IDLE) begin
        busy_q <= bus.start;
        if (bus.start) begin
          base_q    <= 17'(bus.fig_select) * PIX17;
          p_q       <= '0;
          overrun_q <= 1'b0;
          state_q   <= LOAD;
        end
      end else if (bus.abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (wr_d) begin
        state_q <= last_d ? IDLE : left_d != 2'd0 ? EXPAND : LOAD;
        if (last_d && left_d != 2'd0) overrun_q <= 1'b1;
      end
    end
  end
  assign bus.in_ready = state_q == LOAD;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;
endmodule
